fft_addr_gen: RTL
=================

# fft_addr_gen

Butterfly sequencer for the in-place radix-2 decimation-in-time FFT. It sits directly downstream of the sample loader, which writes 32 samples into the working RAM at bit-reversed addresses and then raises `done`. When started by that `done`, this block walks all 5 stages × 16 butterflies. For each butterfly it issues the RAM read/write address pair and the twiddle index to the butterfly datapath through a valid/ready handshake, and it signals `fft_done` when the RAM holds the natural-order result.

## Interface
- `N_LOG2`, default 5: log2 of transform length. N = 32; 16 butterflies per stage; 5 stages.
- `BF_LATENCY`, default 2: butterfly pipeline depth in cycles, range ≥1. Sets the drain gap between stages.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level input, driven by the loader's `done`. Sampled only in IDLE.
- `bf_valid`  out  1  the butterfly descriptor on the outputs is valid.
- `bf_ready`  in  1  the datapath accepts the descriptor. A transfer occurs when `bf_valid & bf_ready`.
- `addr_a`  out  N_LOG2  upper-leg RAM address.
- `addr_b`  out  N_LOG2  lower-leg RAM address; always `addr_a + span`.
- `tw_idx`  out  N_LOG2-1  twiddle index k for W_N^k, range 0..15.
- `stage`  out  3  current stage number, 0..N_LOG2-1.
- `fft_done`  out  1  the transform is complete and the RAM result is stable.

## Operation
- The block has 4 states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `bf_valid`=0, `fft_done`=0.
  - If `start`=1, load stage=0, j=0 and go to RUN.
- RUN:
  - `bf_valid`=1, and outputs reflect (stage, j).
  - On a transfer with j<15: j increments.
  - On a transfer with j=15: go to DRAIN and load the drain counter with BF_LATENCY.
- DRAIN:
  - `bf_valid`=0, and the counter decrements each cycle.
  - When the counter expires after exactly BF_LATENCY cycles:
    - if stage<N_LOG2-1: stage increments, j=0, go to RUN;
    - otherwise go to DONE.
- DONE:
  - `fft_done`=1.
  - Stay in DONE while `start`=1. When `start`=0, go to IDLE.
  - This rule prevents a still-high loader `done` from re-triggering the transform.
- Address arithmetic, for stage s and butterfly j (4 bits):
  - span = 1<<s, pos = j & (span-1), group = j>>s.
  - `addr_a` = (group<<(s+1)) | pos; `addr_b` = `addr_a` + span.
  - `tw_idx` = pos<<(N_LOG2-1-s).
  - All arithmetic is unsigned, and no value overflows N_LOG2 bits.
- Input order is bit-reversed (supplied by the loader); output order is natural.

## Timing
- Every output is registered. Reset values: `bf_valid`=0, `fft_done`=0, `addr_a`=0, `addr_b`=0, `tw_idx`=0, `stage`=0; the state is IDLE.
- The edge that samples `start`=1 in IDLE makes `bf_valid`=1 with stage 0, j=0 on the following cycle. There is no combinational path from `start`.
- While `bf_valid`=1 and `bf_ready`=0, every output holds stable. `bf_valid` never drops without a transfer.
- After a transfer, the next descriptor appears on the next cycle, giving 1 butterfly per cycle with `bf_ready` tied high.
- With `bf_ready`=1, a stage takes 16 + BF_LATENCY cycles. With the defaults, `fft_done` rises 90 edges after the edge that sampled `start`.
- Deasserting `start` during RUN or DRAIN is ignored.
- Reset mid-operation: the next edge forces IDLE with all outputs at their reset values, regardless of any pending handshake.
- Reset and `start` high in the same cycle: reset wins. `start` is then sampled on the following edge.

## Structure
- Shared package `fft_pkg` holds:
  - the `N_LOG2` and `N_BFLY` constants, shared with the loader and the butterfly datapath;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the twiddle-index width.
- Sub-module `fft_bf_index` holds the combinational mapping from (stage, j) to (`addr_a`, `addr_b`, `tw_idx`). The top level holds the FSM, the j and stage counters, the drain counter and the output registers.

## Test plan
- Reset, then `start`=1 with `bf_ready`=1 → first descriptor one cycle later is a=0, b=1, tw=0, stage=0. `fft_done` rises after exactly 90 edges.
- Free run, check selected descriptors:
  - stage0 j3 → a=6, b=7, tw=0;
  - stage2 j5 → a=9, b=13, tw=4;
  - stage4 j15 → a=15, b=31, tw=15.
- Free run, check addresses: each stage covers all 32 addresses exactly once.
- Random `bf_ready` backpressure → outputs stay stable while stalled, the sequence is identical to the free run, and there are no duplicated or skipped descriptors.
- Stage boundary → `bf_valid`=0 for exactly BF_LATENCY cycles. Also run with BF_LATENCY=1 and BF_LATENCY=4.
- `start` held high after `fft_done` → `fft_done` stays high and no restart occurs. Drop `start` → IDLE. Raise `start` again → a full new run.
- Assert `reset` during stage 2 with a stall pending → next cycle IDLE, `bf_valid`=0, all outputs 0. The next run is correct from stage 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Constants and state encoding shared by the FFT loader, butterfly sequencer and datapath.
package fft_pkg;

    localparam int N_LOG2 = 5;
    localparam int N_BFLY = 1 << (N_LOG2 - 1);
    localparam int TW_W   = N_LOG2 - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

endpackage

// File: rtl/fft_bf_index.sv
// Combinational map from (stage, butterfly j) to the in-place DIT address pair and twiddle index.
module fft_bf_index #(
    parameter int N_LOG2 = 5
) (
    input  logic [2:0]        stage,
    input  logic [N_LOG2-2:0] j,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] tw_idx
);

    localparam logic [2:0]        TOP_STAGE = 3'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] ONE       = N_LOG2'(1);

    logic [N_LOG2-1:0] span;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] group;
    logic [2:0]        tw_shift;

    // Butterflies of a stage form groups of 2*span words; pos is the offset inside a group.
    always_comb begin
        span     = ONE << stage;
        pos      = {1'b0, j} & (span - ONE);
        group    = {1'b0, j} >> stage;
        addr_a   = (group << (stage + 3'd1)) | pos;
        addr_b   = addr_a + span;
        tw_shift = TOP_STAGE - stage;
        tw_idx   = (N_LOG2 - 1)'(pos << tw_shift);
    end

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly sequencer: walks every stage and butterfly, issuing RAM addresses and
// twiddle indices over a valid/ready handshake, with a drain gap between stages.
module fft_addr_gen #(
    parameter int N_LOG2     = fft_pkg::N_LOG2,
    parameter int BF_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] tw_idx,
    output logic [2:0]        stage,
    output logic              fft_done
);

    import fft_pkg::*;

    localparam int              JW         = N_LOG2 - 1;
    localparam int              DW         = $clog2(BF_LATENCY + 1);
    localparam logic [JW-1:0]   J_LAST     = JW'((1 << JW) - 1);
    localparam logic [2:0]      STAGE_LAST = 3'(N_LOG2 - 1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(BF_LATENCY);
    localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);

    fft_state_e        state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [JW-1:0]     j_q, j_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              bf_valid_q, bf_valid_d;
    logic              fft_done_q, fft_done_d;
    logic [N_LOG2-1:0] addr_a_q, addr_a_d;
    logic [N_LOG2-1:0] addr_b_q, addr_b_d;
    logic [JW-1:0]     tw_idx_q, tw_idx_d;
    logic [N_LOG2-1:0] idx_a;
    logic [N_LOG2-1:0] idx_b;
    logic [JW-1:0]     idx_tw;

    // Handshake: a descriptor moves on a cycle with bf_valid & bf_ready; while bf_valid is high
    // and bf_ready low, all outputs hold, and bf_valid only falls after a transfer.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                if (bf_ready) begin
                    if (j_q == J_LAST) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_ONE) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + 3'd1;
                        j_d     = '0;
                    end
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            ST_DONE: begin
                // A loader done that stays high must not restart the transform.
                if (!start) begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    fft_bf_index #(
        .N_LOG2(N_LOG2)
    ) u_index (
        .stage (stage_d),
        .j     (j_d),
        .addr_a(idx_a),
        .addr_b(idx_b),
        .tw_idx(idx_tw)
    );

    always_comb begin
        bf_valid_d = (state_d == ST_RUN);
        fft_done_d = (state_d == ST_DONE);
        if (state_d == ST_IDLE) begin
            addr_a_d = '0;
            addr_b_d = '0;
            tw_idx_d = '0;
        end else begin
            addr_a_d = idx_a;
            addr_b_d = idx_b;
            tw_idx_d = idx_tw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            j_q        <= '0;
            drain_q    <= '0;
            bf_valid_q <= 1'b0;
            fft_done_q <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            j_q        <= j_d;
            drain_q    <= drain_d;
            bf_valid_q <= bf_valid_d;
            fft_done_q <= fft_done_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            tw_idx_q   <= tw_idx_d;
        end
    end

    assign bf_valid = bf_valid_q;
    assign fft_done = fft_done_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign tw_idx   = tw_idx_q;
    assign stage    = stage_q;

endmodule
